// File: rtl/feeder_pkg.sv
// feeder_pkg: shared defaults and lane helpers for the skewed window feeder.
//   DEF_*       default parameter values used by skewed_window_feeder
//   lane_lsb    LSB position of lane r in the packed lane_data bus
//   tap_buffer  which line buffer feeds window tap r (tap K-1 is the live pixel)
package feeder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 64;
  localparam int DEF_IMG_H  = 64;
  localparam int DEF_K      = 3;

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

  // Lane 0 is the oldest line, so it reads the deepest buffer.
  function automatic int tap_buffer(input int lane, input int k);
    return k - 2 - lane;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one line of pixel storage, circular, addressed by column.
//   clk    clock
//   wr_en  write din at addr on this edge
//   addr   column pointer shared by all buffers
//   din    pixel written into this line
//   dout   previous content at addr (read happens before the write)
module line_buffer #(
  parameter int  DATA_W = 8,
  parameter int  IMG_W  = 64,
  localparam int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= din;
  end

  // Combinational read returns the old word in the same cycle it is overwritten.
  assign dout = mem[addr];

endmodule

// File: rtl/skewed_window_feeder.sv
// skewed_window_feeder: turns a raster pixel stream into a K-tall window
// column and skews lane r by r cycles, the usual feed for a systolic array.
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     pixel accepted on this edge
//   in_sof       with in_valid: this pixel is (row 0, col 0)
//   in_pixel     raster-order pixel
//   lane_data    lane r in bits [r*DATA_W +: DATA_W], zero when lane invalid
//   lane_valid   per-lane qualifier
//   frame_done   one-cycle pulse after the last pixel of a frame
//   sof_err      one-cycle pulse when in_sof arrives mid-frame
//
// Handshake: no back-pressure. A pixel is consumed on every rising edge where
// in_valid is high; outputs are qualified only by lane_valid and the pulses.
module skewed_window_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [DATA_W-1:0]   in_pixel,
  output logic [K*DATA_W-1:0] lane_data,
  output logic [K-1:0]        lane_valid,
  output logic                frame_done,
  output logic                sof_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  // Position of the pixel on the input: in_sof overrides the counters.
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          window_ok;
  logic          take;
  logic          at_last;
  logic          at_origin;

  always_comb begin
    pos_col   = in_sof ? '0 : col_q;
    pos_row   = in_sof ? '0 : row_q;
    window_ok = (pos_row >= ROW_WIN);
    take      = in_valid && window_ok;
    at_last   = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    at_origin = (col_q == '0) && (row_q == '0);
  end

  // Position counters and frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= in_valid && at_last;
      sof_err    <= in_valid && in_sof && !at_origin;
      if (in_valid) begin
        if (pos_col == COL_LAST) begin
          col_q <= '0;
          row_q <= (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
        end else begin
          col_q <= pos_col + CW'(1);
          row_q <= pos_row;
        end
      end
    end
  end

  // Line buffers form a chain: buffer 0 takes the live pixel, buffer j takes
  // what buffer j-1 is evicting, so buffer j holds line y-1-j.
  logic [DATA_W-1:0] lb_din  [K-1];
  logic [DATA_W-1:0] lb_dout [K-1];

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_din[j] = in_pixel;
    end else begin : g_link
      assign lb_din[j] = lb_dout[j-1];
    end
    line_buffer #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W)
    ) u_line_buffer (
      .clk   (clk),
      .wr_en (in_valid),
      .addr  (pos_col),
      .din   (lb_din[j]),
      .dout  (lb_dout[j])
    );
  end

  // Window column, lane 0 = oldest line.
  logic [DATA_W-1:0] tap [K];

  always_comb begin
    for (int r = 0; r < K; r++) tap[r] = '0;
    tap[K-1] = in_pixel;
    for (int r = 0; r < K - 1; r++) tap[r] = lb_dout[tap_buffer(r, K)];
  end

  // One valid bit per skew stage; stage r qualifies lane r.
  logic [K-1:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= {valid_q[K-2:0], take};
  end

  assign lane_valid = valid_q;

  // Lane r: a chain of r+1 registers. Data is zeroed on entry when the column
  // is not a valid window, so lane_data is already zero whenever invalid.
  for (genvar r = 0; r < K; r++) begin : g_lane
    logic [DATA_W-1:0] chain [r+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d <= r; d++) chain[d] <= '0;
      end else begin
        chain[0] <= take ? tap[r] : '0;
        for (int d = 1; d <= r; d++) chain[d] <= chain[d-1];
      end
    end

    assign lane_data[lane_lsb(r, DATA_W) +: DATA_W] = chain[r];
  end

endmodule

// File: tb/tb_skewed_window_feeder.sv
module tb_skewed_window_feeder;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int K      = 3;
  localparam int SLOTS  = 16;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_sof = 1'b0;
  logic [DATA_W-1:0]   in_pixel = '0;
  logic [K*DATA_W-1:0] lane_data;
  logic [K-1:0]        lane_valid;
  logic                frame_done;
  logic                sof_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  skewed_window_feeder #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  // ---------------- reference model ----------------
  // Expected outputs are scheduled per clock edge (slot = edge number mod SLOTS).
  // The image itself is kept as a plain 2-D array of the current frame.
  logic [K-1:0]      exp_v    [SLOTS];
  logic [DATA_W-1:0] exp_d    [SLOTS][K];
  logic              exp_done [SLOTS];
  logic              exp_err  [SLOTS];
  logic [DATA_W-1:0] img      [IMG_H][IMG_W];
  int mrow = 0;
  int mcol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < SLOTS; i++) begin
      exp_v[i]    = '0;
      exp_done[i] = 1'b0;
      exp_err[i]  = 1'b0;
      for (int r = 0; r < K; r++) exp_d[i][r] = '0;
    end
  endtask

  // Called just before the edge that accepts the pixel (edge number cyc+1).
  task automatic model_accept(input logic s, input logic [DATA_W-1:0] p);
    int e;
    e = cyc + 1;
    if (s) begin
      if (mrow != 0 || mcol != 0) exp_err[e % SLOTS] = 1'b1;
      mrow = 0;
      mcol = 0;
    end
    img[mrow][mcol] = p;
    if (mrow >= K - 1) begin
      for (int r = 0; r < K; r++) begin
        exp_v[(e + r) % SLOTS][r] = 1'b1;
        exp_d[(e + r) % SLOTS][r] = img[mrow - (K - 1) + r][mcol];
      end
    end
    if (mrow == IMG_H - 1 && mcol == IMG_W - 1) exp_done[e % SLOTS] = 1'b1;
    mcol++;
    if (mcol == IMG_W) begin
      mcol = 0;
      mrow = (mrow + 1) % IMG_H;
    end
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    int i;
    i = cyc % SLOTS;
    for (int r = 0; r < K; r++) begin
      chk($sformatf("lane_valid[%0d]", r), 32'(lane_valid[r]), 32'(exp_v[i][r]));
      chk($sformatf("lane_data[%0d]", r), 32'(lane_data[r*DATA_W +: DATA_W]), 32'(exp_d[i][r]));
    end
    chk("frame_done", 32'(frame_done), 32'(exp_done[i]));
    chk("sof_err", 32'(sof_err), 32'(exp_err[i]));
    exp_v[i]    = '0;
    exp_done[i] = 1'b0;
    exp_err[i]  = 1'b0;
    for (int r = 0; r < K; r++) exp_d[i][r] = '0;
  end

  // ---------------- driver tasks ----------------
  // Entered #1 after a rising edge; returns #1 after the next one.
  task automatic step(input logic v, input logic s, input logic [DATA_W-1:0] p);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    if (v) model_accept(s, p);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    clear_sched();
    mrow = 0;
    mcol = 0;
    #1;
    chk("rst lane_valid", 32'(lane_valid), 32'd0);
    chk("rst lane_data", 32'(lane_data), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst sof_err", 32'(sof_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Full frame with in_valid held high, pixel = raster index, plus literal
  // expectations for the first valid window column and the frame end.
  task automatic full_frame_literal();
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      step(1'b1, 1'b0, DATA_W'(i));
      if (i == 7) chk("no window before row 2", 32'(lane_valid), 32'd0);
      if (i == 8) begin
        chk("first lane_valid", 32'(lane_valid), 32'b001);
        chk("first lane0", 32'(lane_data[7:0]), 32'd0);
      end
      if (i == 9) begin
        chk("second lane_valid", 32'(lane_valid), 32'b011);
        chk("second lane1", 32'(lane_data[15:8]), 32'd4);
        chk("second lane0", 32'(lane_data[7:0]), 32'd1);
      end
      if (i == 10) begin
        chk("third lane_valid", 32'(lane_valid), 32'b111);
        chk("third lane2", 32'(lane_data[23:16]), 32'd8);
      end
      if (i == 15) chk("frame_done after 15", 32'(frame_done), 32'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_sched();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset lane_valid", 32'(lane_valid), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Continuous full frame.
    full_frame_literal();

    // Next frame starts with in_sof at (0,0): no error; in_valid toggles.
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      step(1'b1, (i == 0), DATA_W'(i));
      if (i == 0) begin
        chk("sof at origin no err", 32'(sof_err), 32'd0);
        chk("frame_done one cycle", 32'(frame_done), 32'd0);
      end
      if (i == 8) chk("toggle first lane0", 32'(lane_data[7:0]), 32'd0);
      step(1'b0, 1'b0, DATA_W'($urandom_range(0, 255)));
      if (i == 8) chk("toggle gap lane_valid", 32'(lane_valid), 32'b010);
    end

    // in_sof without in_valid is ignored mid-frame.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(i));
    step(1'b0, 1'b1, 8'd99);
    chk("sof ignored no err", 32'(sof_err), 32'd0);
    for (int i = 5; i < IMG_W * IMG_H; i++) step(1'b1, 1'b0, DATA_W'(i));
    chk("frame_done counters kept", 32'(frame_done), 32'd1);

    // in_sof at pixel 6 restarts the frame with an error pulse.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DATA_W'(i));
    step(1'b1, 1'b1, 8'd6);
    chk("mid-frame sof_err", 32'(sof_err), 32'd1);
    for (int j = 1; j < 8; j++) begin
      step(1'b1, 1'b0, DATA_W'(6 + j));
      chk("restart no window", 32'(lane_valid), 32'd0);
    end
    step(1'b1, 1'b0, 8'd14);
    chk("restart first lane_valid", 32'(lane_valid), 32'b001);
    chk("restart first lane0", 32'(lane_data[7:0]), 32'd6);
    for (int j = 9; j < IMG_W * IMG_H; j++) step(1'b1, 1'b0, DATA_W'(6 + j));
    chk("restart frame_done", 32'(frame_done), 32'd1);

    // Reset mid-frame with windows in flight, then a clean frame.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, DATA_W'(i));
    do_reset();
    full_frame_literal();

    // Randomized traffic: gaps, random pixels, stray in_sof, rare resets.
    for (int n = 0; n < 4000; n++) begin
      logic v;
      logic s;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 700) == 0) do_reset();
      else step(v, s, DATA_W'($urandom_range(0, 255)));
    end

    for (int n = 0; n < K + 2; n++) step(1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skewed_window_feeder.md
SKEWED_WINDOW_FEEDER -- requirements
Module: skewed_window_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per line (>= 2).
REQ-003 SHALL have parameter IMG_H, default 64, lines per frame (>= K).
REQ-004 SHALL have parameter K, default 3, window height and lane count (2..8).
REQ-005 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  in_pixel accepted on this edge.
REQ-008 SHALL have port in_sof  input  1  qualified by in_valid; pixel is (row 0, col 0).
REQ-009 SHALL have port in_pixel  input  DATA_W  raster-order pixel.
REQ-010 SHALL have port lane_data  output  K*DATA_W  lane r in bits [r*DATA_W +: DATA_W].
REQ-011 SHALL have port lane_valid  output  K  per-lane qualifier.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of frame.
REQ-013 SHALL have port sof_err  output  1  one-cycle pulse on in_sof before frame end.

Function
REQ-014 SHALL keep K-1 line buffers, each IMG_W deep; buffer j holds line y-1-j relative to current line y.
REQ-015 SHALL advance line buffers and col/row counters only on in_valid; idle cycles leave them unchanged.
REQ-016 SHALL implement line buffers as circular memories sharing one column pointer; read-before-write at the same address.
REQ-017 SHALL form window column: tap K-1 = in_pixel, tap r (r<K-1) = buffer K-2-r (lane 0 = oldest line).
REQ-018 SHALL register window column, then delay lane r by r further cycles; lane r output at acceptance cycle t appears at t+1+r.
REQ-019 SHALL run skew registers every clock regardless of in_valid, carrying a valid bit per stage.
REQ-020 SHALL set window_ok when row counter >= K-1 at acceptance; lane_valid[r] = (in_valid AND window_ok) delayed 1+r cycles.
REQ-021 SHALL drive lane_data to 0 when the corresponding lane_valid is 0.
REQ-022 SHALL wrap column counter IMG_W-1 -> 0 and increment row counter on wrap.
REQ-023 SHALL pulse frame_done one cycle after accepting (row IMG_H-1, col IMG_W-1); counters then return to (0,0).
REQ-024 SHALL force counters to (0,1) after accepting a pixel with in_sof; buffer contents not cleared but gated by window_ok.
REQ-025 SHALL pulse sof_err when in_sof is accepted with counters not at (0,0); frame restarts per REQ-024.
REQ-026 SHALL ignore in_sof when in_valid is 0.
REQ-027 SHALL size counters $clog2(IMG_W) and $clog2(IMG_H) bits; no arithmetic on pixel data.

Reset
REQ-028 SHALL on rst clear counters, skew registers, valid bits, lane_data, lane_valid, frame_done, sof_err to 0.
REQ-029 SHALL leave line-buffer memory uninitialised; window_ok gating makes stale content unobservable.
REQ-030 SHALL abort any frame in progress on rst; next accepted pixel is (0,0) irrespective of in_sof.

Structure
REQ-031 SHALL place lane-index/packing helper constants and default parameter values in shared header feeder_pkg.
REQ-032 SHALL instantiate K-1 copies of sub-module line_buffer (DATA_W, IMG_W; ports clk, wr_en, addr, din, dout).

Verification (K=3, IMG_W=4, IMG_H=4, DATA_W=8, pixel value = raster index)
REQ-033 SHALL cover: full frame, in_valid held high -> first lane_valid[0] at cycle after pixel 8, lane0/1/2 = 0,4,8 at t+1,t+2,t+3.
REQ-034 SHALL cover: in_valid toggling 1/0 -> same lane data sequence as REQ-033, lane_valid gaps matching input gaps.
REQ-035 SHALL cover: last pixel 15 accepted -> frame_done high exactly one cycle, next pixel with in_sof gives no sof_err.
REQ-036 SHALL cover: in_sof at pixel 6 -> sof_err pulse; no lane_valid until 8 further pixels of the new frame.
REQ-037 SHALL cover: rst asserted mid-frame (after pixel 10) -> all outputs 0 same cycle; restart behaves as REQ-033.
REQ-038 SHALL cover: in_sof with in_valid=0 -> no sof_err, counters unchanged.
